config_loader: RTL



---
 rtl/config_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Write sequencer for the configuration latch bank: setup / strobe / hold per word.
// Define CONFIG_LOADER_CHECKSUM_EN to add the trailing XOR checksum word and io_error.
module config_loader #(
   parameter int WORD_W        = 32,
   parameter int NUM_WORDS     = 37,
   parameter int CNT_W         = 6,
   parameter int STROBE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_start,
   input  logic                 io_abort,
   input  logic [WORD_W-1:0]    io_word_in,
   input  logic                 io_word_valid,
   output logic                 io_word_ready,
   output logic [WORD_W-1:0]    io_d_out,
   output logic [NUM_WORDS-1:0] io_configs_en,
   output logic                 io_busy,
   output logic                 io_done,
   output logic                 io_error,
   output logic [CNT_W-1:0]     io_word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_WAIT,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
`ifdef CONFIG_LOADER_CHECKSUM_EN
      , S_CHECK
`endif
   } state_e;

   localparam logic [CNT_W-1:0]     LAST  = CNT_W'(NUM_WORDS - 1);
   localparam logic [3:0]           SLAST = 4'(STROBE_CYCLES - 1);
   localparam logic [NUM_WORDS-1:0] ONE   = {{(NUM_WORDS-1){1'b0}}, 1'b1};

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     idx_q, idx_d;
   logic [3:0]           scnt_q, scnt_d;
   logic [WORD_W-1:0]    dout_q, dout_d;
   logic [NUM_WORDS-1:0] en_q, en_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 take;

`ifdef CONFIG_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]    xor_q, xor_d;
   logic                 err_q, err_d;
`endif

   assign take = ready_q & io_word_valid;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      scnt_d  = scnt_q;
      dout_d  = dout_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      xor_d   = xor_q;
      err_d   = err_q;
`endif
      // Abort wins everywhere, including over a start in IDLE.
      if (io_abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (io_start) begin
                  idx_d   = '0;
                  state_d = S_LOAD_WAIT;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  xor_d   = '0;
                  err_d   = 1'b0;
`endif
               end
            end
            S_LOAD_WAIT: begin
               if (take) begin
                  dout_d  = io_word_in;
                  state_d = S_SETUP;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  xor_d   = xor_q ^ io_word_in;
`endif
               end
            end
            S_SETUP: begin
               scnt_d  = '0;
               state_d = S_STROBE;
            end
            S_STROBE: begin
               if (scnt_q == SLAST) state_d = S_HOLD;
               else scnt_d = scnt_q + 4'd1;
            end
            S_HOLD: begin
               if (idx_q == LAST) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  idx_d   = idx_q + CNT_W'(1);
                  state_d = S_LOAD_WAIT;
               end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (take) begin
                  err_d   = (io_word_in != xor_q);
                  state_d = S_DONE;
               end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      // Outputs are registered, so they are decoded from the next state.
      ready_d = (state_d == S_LOAD_WAIT);
`ifdef CONFIG_LOADER_CHECKSUM_EN
      if (state_d == S_CHECK) ready_d = 1'b1;
`endif
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      en_d   = (state_d == S_STROBE) ? (ONE << idx_d) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         scnt_q  <= '0;
         dout_q  <= '0;
         en_q    <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         scnt_q  <= scnt_d;
         dout_q  <= dout_d;
         en_q    <= en_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef CONFIG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xor_q <= '0;
         err_q <= 1'b0;
      end else begin
         xor_q <= xor_d;
         err_q <= err_d;
      end
   end
   assign io_error = err_q;
`else
   assign io_error = 1'b0;
`endif

   assign io_word_ready = ready_q;
   assign io_d_out      = dout_q;
   assign io_configs_en = en_q;
   assign io_busy       = busy_q;
   assign io_done       = done_q;
   assign io_word_count = idx_q;

endmodule
